// File: rtl/sprite_pkg.sv
// Shared types and keycodes for sprite/enemy motion controllers.
package sprite_pkg;

  typedef enum logic [1:0] {
    MS_GROUND = 2'd0,
    MS_RISE   = 2'd1,
    MS_FALL   = 2'd2
  } motion_state_t;

  localparam logic [7:0] KEY_LEFT  = 8'h04;
  localparam logic [7:0] KEY_RIGHT = 8'h07;
  localparam logic [7:0] KEY_JUMP  = 8'h1A;
  localparam logic [7:0] KEY_DOWN  = 8'h16;

endpackage

// File: rtl/frame_tick_gen.sv
// Converts the frame strobe into a single-Clk tick on its rising edge.
module frame_tick_gen (
  input  logic Clk,
  input  logic Reset,
  input  logic i_strobe,
  output logic o_tick
);

  logic r_strobe_d;
  logic r_tick;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_strobe_d <= 1'b0;
      r_tick     <= 1'b0;
    end else begin
      r_strobe_d <= i_strobe;
      r_tick     <= i_strobe & ~r_strobe_d;
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/sprite_motion_ctrl.sv
// Player sprite motion: walk, gravity, multi-jump, fast-fall, clamped to the play area.
module sprite_motion_ctrl
  import sprite_pkg::*;
#(
  parameter int COORD_W   = 10,
  parameter int VEL_W     = 6,
  parameter int X_MIN     = 203,
  parameter int X_MAX     = 436,
  parameter int Y_MIN     = 152,
  parameter int Y_MAX     = 327,
  parameter int X_START   = 230,
  parameter int Y_START   = 240,
  parameter int WALK_STEP = 2,
  parameter int JUMP_VEL  = 8,
  parameter int GRAVITY   = 1,
  parameter int VMAX_FALL = 8,
  parameter int MAX_JUMPS = 5
) (
  input  logic                             Clk,
  input  logic                             Reset,
  input  logic                             frame_clk,
  input  logic [7:0]                       keycode,
  input  logic [COORD_W-1:0]               DrawX,
  input  logic [COORD_W-1:0]               DrawY,
  input  logic [COORD_W-1:0]               Left_Dis,
  input  logic [COORD_W-1:0]               Right_Dis,
  input  logic [COORD_W-1:0]               Up_Dis,
  input  logic [COORD_W-1:0]               Bottom_Dis,
  output logic [COORD_W-1:0]               pos_x,
  output logic [COORD_W-1:0]               pos_y,
  output logic [COORD_W-1:0]               map_x,
  output logic [COORD_W-1:0]               map_y,
  output logic [1:0]                       mstate,
  output logic                             facing,
  output logic [$clog2(MAX_JUMPS+1)-1:0]   jumps_used,
  output logic                             draw_sprite
);

  localparam int JW = $clog2(MAX_JUMPS + 1);
  localparam logic [COORD_W:0]          LX_MIN  = (COORD_W+1)'(X_MIN);
  localparam logic [COORD_W:0]          LX_MAX  = (COORD_W+1)'(X_MAX);
  localparam logic [COORD_W:0]          LSTEP   = (COORD_W+1)'(WALK_STEP);
  localparam logic signed [COORD_W+1:0] LY_MIN  = (COORD_W+2)'(Y_MIN);
  localparam logic signed [COORD_W+1:0] LY_MAX  = (COORD_W+2)'(Y_MAX);
  localparam logic signed [VEL_W-1:0]   LJUMP   = VEL_W'(-JUMP_VEL);
  localparam logic signed [VEL_W-1:0]   LVMAX   = VEL_W'(VMAX_FALL);
  localparam logic signed [VEL_W:0]     LVMAX_E = (VEL_W+1)'(VMAX_FALL);
  localparam logic signed [VEL_W:0]     LGRAV_E = (VEL_W+1)'(GRAVITY);
  localparam logic [JW-1:0]             LMAXJ   = JW'(MAX_JUMPS);

  logic                      w_tick;
  logic [COORD_W-1:0]        r_x, r_y, w_x_next, w_y_next;
  logic signed [VEL_W-1:0]   r_vy, w_vy_next, w_vy_cmd;
  logic signed [VEL_W:0]     w_vy_grav;
  logic signed [COORD_W+1:0] w_y_sum;
  logic [COORD_W:0]          w_x_right;
  motion_state_t             r_mstate, w_mstate_next;
  logic                      r_facing, w_facing_next;
  logic [JW-1:0]             r_jumps, w_jumps_next, w_jumps_cmd;
  logic                      r_prev_jump, w_is_jump, w_jp, w_airborne;

  frame_tick_gen u_tick (
    .Clk      (Clk),
    .Reset    (Reset),
    .i_strobe (frame_clk),
    .o_tick   (w_tick)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_x         <= COORD_W'(X_START);
      r_y         <= COORD_W'(Y_START);
      r_vy        <= '0;
      r_mstate    <= MS_FALL;
      r_facing    <= 1'b1;
      r_jumps     <= '0;
      r_prev_jump <= 1'b0;
    end else if (w_tick) begin
      r_x         <= w_x_next;
      r_y         <= w_y_next;
      r_vy        <= w_vy_next;
      r_mstate    <= w_mstate_next;
      r_facing    <= w_facing_next;
      r_jumps     <= w_jumps_next;
      r_prev_jump <= w_is_jump;
    end
  end

  always_comb begin
    w_x_next      = r_x;
    w_facing_next = r_facing;
    w_x_right     = {1'b0, r_x} + LSTEP;
    if (keycode == KEY_LEFT) begin
      w_facing_next = 1'b0;
      // Test before subtracting so the left clamp can never wrap.
      if ({1'b0, r_x} < LX_MIN + LSTEP) w_x_next = LX_MIN[COORD_W-1:0];
      else                              w_x_next = r_x - LSTEP[COORD_W-1:0];
    end else if (keycode == KEY_RIGHT) begin
      w_facing_next = 1'b1;
      if (w_x_right > LX_MAX) w_x_next = LX_MAX[COORD_W-1:0];
      else                    w_x_next = w_x_right[COORD_W-1:0];
    end

    w_is_jump   = (keycode == KEY_JUMP);
    w_jp        = w_is_jump & ~r_prev_jump;
    w_airborne  = (r_mstate != MS_GROUND);
    w_vy_grav   = (VEL_W+1)'(r_vy) + LGRAV_E;
    w_jumps_cmd = r_jumps;
    if (w_jp && (r_jumps < LMAXJ)) begin
      w_vy_cmd    = LJUMP;
      w_jumps_cmd = r_jumps + JW'(1);
    end else if (w_airborne && (keycode == KEY_DOWN)) begin
      w_vy_cmd = LVMAX;
    end else if (w_airborne) begin
      w_vy_cmd = (w_vy_grav > LVMAX_E) ? LVMAX : w_vy_grav[VEL_W-1:0];
    end else begin
      w_vy_cmd = '0;
    end

    w_y_sum = signed'({2'b00, r_y}) + (COORD_W+2)'(w_vy_cmd);
    w_y_next      = w_y_sum[COORD_W-1:0];
    w_vy_next     = w_vy_cmd;
    w_jumps_next  = w_jumps_cmd;
    w_mstate_next = (w_vy_cmd < 0) ? MS_RISE : MS_FALL;
    if (w_y_sum >= LY_MAX) begin
      w_y_next      = LY_MAX[COORD_W-1:0];
      w_vy_next     = '0;
      w_mstate_next = MS_GROUND;
      w_jumps_next  = '0;
    end else if (w_y_sum <= LY_MIN) begin
      w_y_next      = LY_MIN[COORD_W-1:0];
      w_vy_next     = '0;
      w_mstate_next = MS_FALL;
    end
  end

  // Hitbox sums carry one extra bit so edge-of-screen extents never wrap.
  always_comb begin
    draw_sprite = ({1'b0, DrawX} + {1'b0, Left_Dis} >= {1'b0, r_x})
                & ({1'b0, DrawX} <= {1'b0, r_x} + {1'b0, Right_Dis})
                & ({1'b0, DrawY} + {1'b0, Up_Dis} >= {1'b0, r_y})
                & ({1'b0, DrawY} <= {1'b0, r_y} + {1'b0, Bottom_Dis});
  end

  assign pos_x      = r_x;
  assign pos_y      = r_y;
  assign map_x      = r_x - COORD_W'(X_MIN);
  assign map_y      = r_y - COORD_W'(Y_MIN);
  assign mstate     = r_mstate;
  assign facing     = r_facing;
  assign jumps_used = r_jumps;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Randomised scoreboard bench for sprite_motion_ctrl against a per-frame behavioural model.
module tb_sprite_motion_ctrl;

  localparam int XMIN = 203, XMAX = 436, YMIN = 152, YMAX = 327;
  localparam int XS = 230, YS = 240, STEP = 2, JV = 8, GR = 1, VMAX = 8, MAXJ = 5;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_clk = 1'b0;
  logic [7:0] keycode = 8'h00;
  logic [9:0] DrawX = '0, DrawY = '0;
  logic [9:0] Left_Dis = '0, Right_Dis = '0, Up_Dis = '0, Bottom_Dis = '0;
  logic [9:0] pos_x, pos_y, map_x, map_y;
  logic [1:0] mstate;
  logic       facing;
  logic [2:0] jumps_used;
  logic       draw_sprite;

  sprite_motion_ctrl dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .keycode(keycode),
    .DrawX(DrawX), .DrawY(DrawY), .Left_Dis(Left_Dis), .Right_Dis(Right_Dis),
    .Up_Dis(Up_Dis), .Bottom_Dis(Bottom_Dis), .pos_x(pos_x), .pos_y(pos_y),
    .map_x(map_x), .map_y(map_y), .mstate(mstate), .facing(facing),
    .jumps_used(jumps_used), .draw_sprite(draw_sprite)
  );

  always #10 Clk = ~Clk;

  typedef struct {
    int x; int y; int ms; int face; int jumps; int draw;
  } exp_t;
  exp_t q[$];

  int checks = 0;
  int failures = 0;
  int m_x, m_y, m_vy, m_ms, m_face, m_jumps, m_prev;

  function automatic void check(string name, int act, int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endfunction

  function automatic void model_reset();
    m_x = XS; m_y = YS; m_vy = 0; m_ms = 2; m_face = 1; m_jumps = 0; m_prev = 0;
  endfunction

  // One frame of motion, straight from the rules: walk, jump edge, velocity, clamp.
  function automatic void model_step(int key);
    int ny;
    bit jp, air;
    if (key == 'h04) begin m_face = 0; m_x = (m_x - STEP < XMIN) ? XMIN : m_x - STEP; end
    if (key == 'h07) begin m_face = 1; m_x = (m_x + STEP > XMAX) ? XMAX : m_x + STEP; end
    jp = (key == 'h1A) && (m_prev == 0);
    m_prev = (key == 'h1A);
    air = (m_ms != 0);
    if (jp && m_jumps < MAXJ) begin m_vy = -JV; m_jumps++; end
    else if (air && key == 'h16) m_vy = VMAX;
    else if (air) m_vy = (m_vy + GR > VMAX) ? VMAX : m_vy + GR;
    else m_vy = 0;
    ny = m_y + m_vy;
    if (ny >= YMAX) begin m_y = YMAX; m_vy = 0; m_ms = 0; m_jumps = 0; end
    else if (ny <= YMIN) begin m_y = YMIN; m_vy = 0; m_ms = 2; end
    else begin m_y = ny; m_ms = (m_vy < 0) ? 1 : 2; end
  endfunction

  function automatic int draw_exp(int px, int py);
    int dx, dy;
    dx = int'(DrawX); dy = int'(DrawY);
    return ((dx + int'(Left_Dis) >= px) && (dx <= px + int'(Right_Dis)) &&
            (dy + int'(Up_Dis) >= py) && (dy <= py + int'(Bottom_Dis))) ? 1 : 0;
  endfunction

  function automatic exp_t snapshot();
    exp_t e;
    e.x = m_x; e.y = m_y; e.ms = m_ms; e.face = m_face; e.jumps = m_jumps;
    e.draw = draw_exp(m_x, m_y);
    return e;
  endfunction

  task automatic frame(input logic [7:0] key);
    @(posedge Clk); #1;
    keycode = key;
    model_step(int'(key));
    DrawX = 10'(m_x + int'($urandom_range(0, 40)) - 20);
    DrawY = 10'(m_y + int'($urandom_range(0, 40)) - 20);
    Left_Dis = 10'($urandom_range(0, 20)); Right_Dis = 10'($urandom_range(0, 20));
    Up_Dis = 10'($urandom_range(0, 20));   Bottom_Dis = 10'($urandom_range(0, 20));
    q.push_back(snapshot());
    frame_clk = 1'b1;
    @(posedge Clk); #1 frame_clk = 1'b0;
    @(posedge Clk);
    @(posedge Clk); #1;
  endtask

  task automatic check_reset_state(string tag);
    check({tag, "_x"}, int'(pos_x), XS);
    check({tag, "_y"}, int'(pos_y), YS);
    check({tag, "_mstate"}, int'(mstate), 2);
    check({tag, "_facing"}, int'(facing), 1);
    check({tag, "_jumps"}, int'(jumps_used), 0);
  endtask

  task automatic draw_point(string name, int dx, int dy, int req);
    DrawX = 10'(dx); DrawY = 10'(dy);
    #1 check(name, int'(draw_sprite), req);
  endtask

  // Monitor: each frame strobe rise produces exactly one state update two Clks later.
  initial begin
    int cnt;
    bit fc_q;
    exp_t e;
    cnt = 0; fc_q = 1'b0;
    forever begin
      @(negedge Clk);
      if (frame_clk && !fc_q) cnt = 2;
      else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          if (q.size() == 0) check("sb_underflow", 1, 0);
          else begin
            e = q.pop_front();
            check("x", int'(pos_x), e.x);
            check("y", int'(pos_y), e.y);
            check("map_x", int'(map_x), e.x - XMIN);
            check("map_y", int'(map_y), e.y - YMIN);
            check("mstate", int'(mstate), e.ms);
            check("facing", int'(facing), e.face);
            check("jumps_used", int'(jumps_used), e.jumps);
            check("draw_sprite", int'(draw_sprite), e.draw);
          end
        end
      end
      fc_q = frame_clk;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    logic [7:0] k;
    model_reset();
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b0;
    check_reset_state("reset");

    Left_Dis = 10'd14; Right_Dis = 10'd14; Up_Dis = 10'd14; Bottom_Dis = 10'd14;
    draw_point("draw_216", 216, 240, 1);
    draw_point("draw_244", 244, 240, 1);
    draw_point("draw_215", 215, 240, 0);
    draw_point("draw_245", 245, 240, 0);
    Left_Dis = 10'd0; Right_Dis = 10'd0; Up_Dis = 10'd1; Bottom_Dis = 10'd1023;
    draw_point("draw_nowrap", 230, 1023, 1);

    repeat (16) frame(8'h00);
    repeat (110) frame(8'h07);
    repeat (120) frame(8'h04);
    repeat (20) frame(8'h1A);
    frame(8'h00);
    frame(8'h1A);
    repeat (6) begin frame(8'h00); frame(8'h1A); end
    repeat (30) frame(8'h00);

    // Jump at each apex to climb into the ceiling.
    repeat (60) frame((m_vy >= 0 && m_prev == 0) ? 8'h1A : 8'h00);
    repeat (3) frame(8'h16);
    repeat (2) frame(8'h1A);
    frame(8'h00);

    // Reset while airborne with a strobe in flight.
    @(posedge Clk); #1;
    Reset = 1'b1; frame_clk = 1'b1; keycode = 8'h00;
    model_reset();
    q.push_back(snapshot());
    @(posedge Clk); #1 frame_clk = 1'b0;
    @(posedge Clk);
    @(posedge Clk); #1 Reset = 1'b0;
    check_reset_state("midair_reset");

    repeat (300) begin
      r = int'($urandom_range(0, 9));
      case (r)
        2, 3:    k = 8'h04;
        4, 5:    k = 8'h07;
        6, 7:    k = 8'h1A;
        8:       k = 8'h16;
        9:       k = 8'($urandom);
        default: k = 8'h00;
      endcase
      frame(k);
    end

    repeat (20) if (q.size() != 0) @(posedge Clk);
    check("scoreboard_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
